// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: edit-mode sequencer for the century clock; issues adjust strobes, blink and commit.
// Optional idle auto-exit to RUN is compiled in with `define SET_TIMEOUT_EN.
module clock_set_ctrl #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BLINK_HZ  = 2,
    parameter int TIMEOUT_S = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_p,
    input  logic       inc_p,
    input  logic       dec_p,
    output logic       run_en,
    output logic [2:0] field_sel,
    output logic       adj_inc,
    output logic       adj_dec,
    output logic       blink,
    output logic       commit
);
    localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int BW   = HALF > 1 ? $clog2(HALF) : 1;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        SET_SEC  = 3'd1,
        SET_MIN  = 3'd2,
        SET_HOUR = 3'd3,
        SET_DAY  = 3'd4,
        SET_MON  = 3'd5,
        SET_YEAR = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic          adj_inc_q, adj_inc_d, adj_dec_q, adj_dec_d;
    logic          blink_q, blink_d, commit_q, commit_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          editing, inc_ok, dec_ok, entry, bcnt_end, timeout;

    assign editing = state_q != RUN;
    // mode_p wins over inc/dec; simultaneous inc+dec cancel each other
    assign inc_ok  = editing && inc_p && !dec_p && !mode_p;
    assign dec_ok  = editing && dec_p && !inc_p && !mode_p;

`ifdef SET_TIMEOUT_EN
    localparam int PW = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
    localparam int IW = TIMEOUT_S > 1 ? $clog2(TIMEOUT_S) : 1;
    logic [PW-1:0] presc_q, presc_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          any_p, wrap;
    always_comb begin
        any_p   = mode_p | inc_p | dec_p;
        wrap    = presc_q == PW'(CLK_HZ - 1);
        timeout = editing && !any_p && wrap && idle_q == IW'(TIMEOUT_S - 1);
        presc_d = (!editing || any_p || wrap) ? '0 : presc_q + PW'(1);
        idle_d  = (!editing || any_p) ? '0 : wrap ? idle_q + IW'(1) : idle_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            idle_q  <= '0;
        end else begin
            presc_q <= presc_d;
            idle_q  <= idle_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT_S > 0;
    assign timeout        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        if (mode_p)
            state_d = state_q == SET_YEAR ? RUN : state_t'(state_q + 3'd1);
        else if (timeout)
            state_d = RUN;
        adj_inc_d = inc_ok;
        adj_dec_d = dec_ok;
        commit_d  = editing && state_d == RUN;
        entry     = state_d != RUN && state_d != state_q;
        bcnt_end  = bcnt_q == BW'(HALF - 1);
        // field is forced visible when entered or adjusted, so the user sees the change
        blink_d   = state_d == RUN ? 1'b0 : (entry || inc_ok || dec_ok) ? 1'b1 : bcnt_end ? !blink_q : blink_q;
        bcnt_d    = (state_d == RUN || entry || inc_ok || dec_ok || bcnt_end) ? '0 : bcnt_q + BW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            adj_inc_q <= 1'b0;
            adj_dec_q <= 1'b0;
            blink_q   <= 1'b0;
            commit_q  <= 1'b0;
            bcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            adj_inc_q <= adj_inc_d;
            adj_dec_q <= adj_dec_d;
            blink_q   <= blink_d;
            commit_q  <= commit_d;
            bcnt_q    <= bcnt_d;
        end
    end

    assign field_sel = state_q;
    assign run_en    = state_q == RUN;
    assign adj_inc   = adj_inc_q;
    assign adj_dec   = adj_dec_q;
    assign blink     = blink_q;
    assign commit    = commit_q;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: scoreboard bench for clock_set_ctrl (CLK_HZ=100, BLINK_HZ=5, TIMEOUT_S=3).
module tb_clock_set_ctrl;
    localparam int FS = 0, RE = 1, AI = 2, AD = 3, BL = 4, CM = 5;

    logic       clk = 1'b0, rst = 1'b1, mode_p = 1'b0, inc_p = 1'b0, dec_p = 1'b0;
    logic       run_en, adj_inc, adj_dec, blink, commit;
    logic [2:0] field_sel;
    int         cyc = 0, n_tests = 0, n_fail = 0;

    typedef struct {
        int    at;
        int    sig;
        int    val;
        string tag;
    } exp_t;
    exp_t sb[$];

    clock_set_ctrl #(.CLK_HZ(100), .BLINK_HZ(5), .TIMEOUT_S(3)) dut (
        .clk(clk), .rst(rst), .mode_p(mode_p), .inc_p(inc_p), .dec_p(dec_p),
        .run_en(run_en), .field_sel(field_sel), .adj_inc(adj_inc), .adj_dec(adj_dec),
        .blink(blink), .commit(commit)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] sample(int sig);
        case (sig)
            FS:      return {29'd0, field_sel};
            RE:      return {31'd0, run_en};
            AI:      return {31'd0, adj_inc};
            AD:      return {31'd0, adj_dec};
            BL:      return {31'd0, blink};
            default: return {31'd0, commit};
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    // outputs are sampled on the falling edge, half a cycle after they settle
    always @(negedge clk)
        for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].at == cyc) begin
                check(sb[i].tag, sample(sb[i].sig), sb[i].val);
                sb.delete(i);
            end

    task automatic want(int dc, int sig, int val, string tag);
        sb.push_back('{cyc + dc, sig, val, tag});
    endtask

    task automatic pulse(logic m, logic i, logic d);
        {mode_p, inc_p, dec_p} = {m, i, d};
        @(negedge clk);
        {mode_p, inc_p, dec_p} = 3'b000;
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic to_run(int n);
        repeat (n - 1) pulse(1, 0, 0);
        want(1, CM, 1, "exit_commit");
        want(1, FS, 0, "exit_fs");
        want(2, CM, 0, "exit_commit_1cyc");
        pulse(1, 0, 0);
        tick(2);
    endtask

    initial begin
        @(negedge clk);
        want(1, FS, 0, "reset_fs");
        want(1, RE, 1, "reset_run");
        want(1, AI, 0, "reset_inc");
        want(1, AD, 0, "reset_dec");
        want(1, BL, 0, "reset_blink");
        want(1, CM, 0, "reset_commit");
        tick(2);
        rst = 1'b0;
        tick(2);
        for (int k = 1; k <= 7; k++) begin
            want(1, FS, k % 7, "seq_fs");
            want(1, RE, int'(k == 7), "seq_run");
            want(1, CM, int'(k == 7), "seq_commit");
            if (k == 7) begin
                want(2, CM, 0, "seq_commit_1cyc");
                want(4, RE, 1, "seq_run_after");
            end else
                want(4, RE, 0, "seq_run_hold");
            pulse(1, 0, 0);
            tick(4);
        end
        want(1, AI, 0, "run_inc_ignored");
        pulse(0, 1, 0);
        want(1, AD, 0, "run_dec_ignored");
        pulse(0, 0, 1);
        tick(1);
        repeat (3) pulse(1, 0, 0);
        want(1, FS, 3, "hour_fs");
        want(1, AI, 1, "hour_inc");
        want(1, AD, 0, "hour_inc_no_dec");
        want(2, AI, 0, "hour_inc_1cyc");
        pulse(0, 1, 0);
        tick(2);
        want(1, AD, 1, "hour_dec");
        want(1, AI, 0, "hour_dec_no_inc");
        want(2, AD, 0, "hour_dec_1cyc");
        pulse(0, 0, 1);
        tick(2);
        want(1, AI, 0, "both_no_inc");
        want(1, AD, 0, "both_no_dec");
        pulse(0, 1, 1);
        tick(2);
        to_run(4);
        repeat (2) pulse(1, 0, 0);
        want(1, FS, 3, "mode_inc_fs");
        want(1, AI, 0, "mode_inc_dropped");
        want(2, AI, 0, "mode_inc_dropped2");
        pulse(1, 1, 0);
        tick(2);
        to_run(4);
        want(1, BL, 1, "blink_on_first");
        want(10, BL, 1, "blink_on_last");
        want(11, BL, 0, "blink_off_first");
        want(14, BL, 0, "blink_off_mid");
        want(15, AI, 1, "blink_adj_strobe");
        want(16, BL, 1, "blink_forced");
        want(24, BL, 1, "blink_restart_last");
        want(25, BL, 0, "blink_restart_off");
        pulse(1, 0, 0);
        tick(13);
        pulse(0, 1, 0);
        tick(11);
        to_run(6);
        repeat (4) pulse(1, 0, 0);
`ifdef SET_TIMEOUT_EN
        want(299, FS, 4, "to_hold");
        want(300, FS, 0, "to_exit");
        want(300, CM, 1, "to_commit");
        want(301, CM, 0, "to_commit_1cyc");
        tick(302);
        repeat (4) pulse(1, 0, 0);
        want(549, FS, 4, "to_ext_hold");
        want(550, FS, 0, "to_ext_exit");
        want(550, CM, 1, "to_ext_commit");
        tick(249);
        pulse(0, 1, 0);
        tick(302);
`else
        want(300, FS, 4, "no_to_300");
        want(1000, FS, 4, "no_to_1000");
        want(1000, RE, 0, "no_to_run");
        tick(1001);
        to_run(3);
`endif
        repeat (6) pulse(1, 0, 0);
        want(1, FS, 0, "rst_mid_fs");
        want(1, RE, 1, "rst_mid_run");
        want(1, BL, 0, "rst_mid_blink");
        want(1, CM, 0, "rst_mid_commit");
        want(2, CM, 0, "rst_mid_commit2");
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(3);
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at cyc %0d, expected finish earlier", cyc);
        $fatal(1);
    end
endmodule
